// File: rtl/pdp8_eae_datapath.sv
// pdp8_eae_datapath: PDP-8 accumulator datapath with EAE shift-add multiply and restoring divide.
module pdp8_eae_datapath #(
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] swreg,
  input  logic             abort,
  output logic             op_ready,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] mq,
  output logic             lk
);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DVI_RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] w_a, w_q, w_m, na, nq;
  logic [WIDTH:0] tad, sum, shl;
  logic accept, dvi_ovf, last, fits;
  always_comb begin
    op_ready = state == IDLE;
    accept = op_valid && op_ready;
    dvi_ovf = ac >= operand;
    last = cnt == CNT_W'(1);
    tad = {1'b0, ac} + {1'b0, operand};
    sum = {1'b0, w_a} + (w_q[0] ? {1'b0, w_m} : '0);
    shl = {w_a, w_q[WIDTH-1]};
    fits = shl >= {1'b0, w_m};
    na = state == MUL_RUN ? sum[WIDTH:1] : (fits ? shl[WIDTH-1:0] - w_m : shl[WIDTH-1:0]);
    nq = state == MUL_RUN ? {sum[0], w_q[WIDTH-1:1]} : {w_q[WIDTH-2:0], fits};
    state_n = state;
    if (accept && op_code == 4'd8)
      state_n = MUL_RUN;
    else if (accept && op_code == 4'd9 && !dvi_ovf)
      state_n = DVI_RUN;
    else if (state != IDLE && (abort || last))
      state_n = IDLE;
  end
  always_ff @(posedge clock)
    if (!resetN)
      state <= IDLE;
    else
      state <= state_n;
  always_ff @(posedge clock) begin
    if (!resetN) begin
      ac <= '0;
      mq <= '0;
      lk <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      cnt <= '0;
      w_a <= '0;
      w_q <= '0;
      w_m <= '0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      if (accept) begin
        done <= state_n == IDLE;
        if (state_n != IDLE) begin
          cnt <= CNT_W'(WIDTH);
          w_a <= ac;
          w_q <= mq;
          w_m <= operand;
        end
        case (op_code)
          4'd1: ac <= '0;
          4'd2: begin
            ac <= tad[WIDTH-1:0];
            lk <= lk ^ tad[WIDTH];
          end
          4'd3: ac <= ac & operand;
          4'd4: ac <= swreg;
          4'd5: ac <= ac | swreg;
          4'd6: begin
            ac <= mq;
            mq <= ac;
          end
          4'd7: begin
            mq <= ac;
            ac <= '0;
          end
          4'd9: if (dvi_ovf) lk <= 1'b1;
          default: ;
        endcase
      end else if (state != IDLE) begin
        if (abort) begin
          aborted <= 1'b1;
          cnt <= '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
          w_a <= na;
          w_q <= nq;
          if (last) begin
            ac <= na;
            mq <= nq;
            lk <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pdp8_eae_datapath.sv
// tb_pdp8_eae_datapath: randomized and directed checks against an arithmetic reference model.
module tb_pdp8_eae_datapath;
  localparam int W = 12;
  localparam longint MASK = (64'd1 << W) - 1;
  logic clock = 1'b0;
  logic resetN, op_valid, abort, op_ready, done, aborted, lk;
  logic [3:0] op_code;
  logic [W-1:0] operand, swreg, ac, mq;
  int n_tests = 0, n_fail = 0;
  longint m_ac = 0, m_mq = 0, m_lk = 0;
  bit busy_swp = 0;
  pdp8_eae_datapath #(.WIDTH(W)) dut (
    .clock(clock), .resetN(resetN), .op_valid(op_valid), .op_code(op_code),
    .operand(operand), .swreg(swreg), .abort(abort), .op_ready(op_ready),
    .done(done), .aborted(aborted), .ac(ac), .mq(mq), .lk(lk)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic run_op(input int op, input longint opd, input longint sw, input int abort_at);
    longint e_ac, e_mq, e_lk, d;
    bit multi;
    e_ac = m_ac;
    e_mq = m_mq;
    e_lk = m_lk;
    multi = 0;
    case (op)
      1: e_ac = 0;
      2: begin
        e_ac = (m_ac + opd) & MASK;
        if (m_ac + opd > MASK) e_lk = m_lk ^ 1;
      end
      3: e_ac = m_ac & opd;
      4: e_ac = sw;
      5: e_ac = m_ac | sw;
      6: begin
        e_ac = m_mq;
        e_mq = m_ac;
      end
      7: begin
        e_mq = m_ac;
        e_ac = 0;
      end
      8: begin
        multi = 1;
        d = m_mq * opd + m_ac;
        e_ac = d >> W;
        e_mq = d & MASK;
        e_lk = 0;
      end
      9: if (m_ac >= opd) e_lk = 1;
      else begin
        multi = 1;
        d = (m_ac << W) | m_mq;
        e_mq = d / opd;
        e_ac = d % opd;
        e_lk = 0;
      end
      default: ;
    endcase
    op_valid = 1;
    op_code = 4'(op);
    operand = W'(opd);
    swreg = W'(sw);
    step();
    if (!multi) begin
      op_valid = 0;
      check("single_done", done, 1);
      check("single_aborted", aborted, 0);
      check("single_ready", op_ready, 1);
      check("single_ac", ac, e_ac);
      check("single_mq", mq, e_mq);
      check("single_lk", lk, e_lk);
    end else begin
      op_valid = busy_swp;
      if (busy_swp) op_code = 4'd6;
      check("busy_ready", op_ready, 0);
      check("busy_done", done, 0);
      check("busy_ac_hold", ac, m_ac);
      for (int i = 1; i <= W; i++) begin
        abort = (i == abort_at);
        step();
        abort = 0;
        if (i == abort_at) begin
          op_valid = 0;
          check("abort_pulse", aborted, 1);
          check("abort_no_done", done, 0);
          check("abort_ready", op_ready, 1);
          check("abort_ac", ac, m_ac);
          check("abort_mq", mq, m_mq);
          check("abort_lk", lk, m_lk);
          e_ac = m_ac;
          e_mq = m_mq;
          e_lk = m_lk;
          break;
        end
        if (i == W) begin
          op_valid = 0;
          check("multi_done", done, 1);
          check("multi_aborted", aborted, 0);
          check("multi_ready", op_ready, 1);
          check("multi_ac", ac, e_ac);
          check("multi_mq", mq, e_mq);
          check("multi_lk", lk, e_lk);
        end else begin
          check("run_ready", op_ready, 0);
          check("run_done", done, 0);
          check("run_ac_hold", ac, m_ac);
          check("run_mq_hold", mq, m_mq);
        end
      end
    end
    m_ac = e_ac;
    m_mq = e_mq;
    m_lk = e_lk;
    step();
    check("done_one_cycle", done, 0);
    check("aborted_one_cycle", aborted, 0);
  endtask
  initial begin
    int op, ab;
    longint opd;
    resetN = 0;
    op_valid = 0;
    abort = 0;
    op_code = 0;
    operand = 0;
    swreg = 0;
    step();
    step();
    check("rst_ac", ac, 0);
    check("rst_mq", mq, 0);
    check("rst_lk", lk, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_ready", op_ready, 1);
    resetN = 1;
    step();
    run_op(4, 0, 'o7777, 0);
    run_op(2, 1, 0, 0);
    check("tad_wrap_ac", ac, 0);
    check("tad_wrap_lk", lk, 1);
    run_op(1, 0, 0, 0);
    run_op(4, 0, 100, 0);
    run_op(6, 0, 0, 0);
    run_op(8, 50, 0, 0);
    check("mul_ac_direct", ac, 1);
    check("mul_mq_direct", mq, 904);
    run_op(1, 0, 0, 0);
    run_op(7, 0, 0, 0);
    run_op(4, 0, 1, 0);
    run_op(9, 16, 0, 0);
    check("dvi_mq_direct", mq, 256);
    check("dvi_ac_direct", ac, 0);
    run_op(4, 0, 5, 0);
    run_op(9, 5, 0, 0);
    check("dvi_ovf_lk", lk, 1);
    check("dvi_ovf_ac", ac, 5);
    run_op(9, 0, 0, 0);
    run_op(8, 77, 0, 4);
    run_op(8, 123, 0, W);
    busy_swp = 1;
    run_op(8, 9, 0, 0);
    busy_swp = 0;
    abort = 1;
    run_op(2, 3, 0, 0);
    abort = 0;
    run_op(1, 0, 0, 0);
    run_op(4, 0, 'h0ab, 0);
    run_op(7, 0, 0, 0);
    run_op(4, 0, 2, 0);
    op_valid = 1;
    op_code = 4'd9;
    operand = 7;
    step();
    op_valid = 0;
    step();
    step();
    resetN = 0;
    step();
    check("midrst_ac", ac, 0);
    check("midrst_mq", mq, 0);
    check("midrst_lk", lk, 0);
    check("midrst_done", done, 0);
    check("midrst_aborted", aborted, 0);
    resetN = 1;
    step();
    check("midrst_ready", op_ready, 1);
    check("midrst_no_done", done, 0);
    m_ac = 0;
    m_mq = 0;
    m_lk = 0;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 15);
      opd = longint'($urandom) & MASK;
      if (op == 9 && m_ac < MASK && $urandom_range(0, 1) == 1)
        opd = longint'($urandom_range(int'(MASK), int'(m_ac) + 1));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, W)) : 0;
      busy_swp = $urandom_range(0, 3) == 0;
      run_op(op, opd, longint'($urandom) & MASK, ab);
    end
    busy_swp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
